// File: rtl/ecc_fault_injector_if.sv
// Cache-side bus of the ECC fault injector.
// The injector drives the bit-flip target index into the dcache and receives
// the cache's echo of the applied flip together with its per-cycle ECC event
// pulses. The injector takes the master modport; the cache, or a model of it,
// takes the slave modport.
interface ecc_fault_injector_if #(
    parameter int INDEX_WIDTH = 12,
    parameter int EVT_WIDTH   = 6
);
    logic [EVT_WIDTH-1:0]   counters_i;
    logic [INDEX_WIDTH-1:0] echo_addr_i;
    logic [INDEX_WIDTH-1:0] bitflip_addr_o;

    modport master (
        output bitflip_addr_o,
        input  counters_i,
        input  echo_addr_i
    );

    modport slave (
        input  bitflip_addr_o,
        output counters_i,
        output echo_addr_i
    );
endinterface

// File: rtl/ecc_fault_injector.sv
// ECC fault injector for the dcache.
// While enable_i is high the injector waits period_i cycles and then presents
// one target index on bitflip_addr_o for a single cycle. It waits up to TIMEOUT
// cycles for the cache to echo that index back, then moves on to the next
// target. Separately, it keeps a saturating accumulator per ECC event line,
// readable through a registered select port.
// Build option: define ECC_INJ_LFSR_EN to step the target with a 16-bit LFSR
// instead of the default sequential +1 advance.
module ecc_fault_injector #(
    parameter int                     INDEX_WIDTH = 12,
    parameter int                     EVT_WIDTH   = 6,
    parameter int                     ACC_WIDTH   = 16,
    parameter logic [INDEX_WIDTH-1:0] IDLE_ADDR   = '1,
    parameter int                     TIMEOUT     = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [15:0]          period_i,
    input  logic                 clear_i,
    input  logic [2:0]           rd_sel_i,
    output logic [ACC_WIDTH-1:0] rd_data_o,
    output logic [ACC_WIDTH-1:0] inj_count_o,
    output logic                 timeout_o,
    output logic                 busy_o,
    ecc_fault_injector_if.master cache
);

    // The timeout counter only has to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_INJECT,
        ST_ACK
    } state_t;

    state_t                 state_reg;
    logic [15:0]            count_reg;
    logic [TW-1:0]          tcnt_reg;
    logic [INDEX_WIDTH-1:0] target_reg;
    logic [INDEX_WIDTH-1:0] target_next;
    logic [INDEX_WIDTH-1:0] bitflip_reg;
    logic [ACC_WIDTH-1:0]   inj_count_reg;
    logic [ACC_WIDTH-1:0]   rd_data_reg;
    logic                   timeout_reg;
    logic                   busy_reg;

    logic [15:0]            period_load;
    logic                   echo_hit;
    logic                   echo_expired;
    logic                   advance;

    // Decode the ACK outcome for this cycle; a period of 0 behaves like 1.
    always_comb begin
        period_load  = (period_i == 16'd0) ? 16'd1 : period_i;
        echo_hit     = enable_i && (state_reg == ST_ACK) &&
                       (cache.echo_addr_i == target_reg);
        echo_expired = enable_i && (state_reg == ST_ACK) && !echo_hit &&
                       (tcnt_reg == TW'(TIMEOUT - 1));
        advance      = echo_hit || echo_expired;
    end

`ifdef ECC_INJ_LFSR_EN
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    // One Fibonacci step, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Step once, then keep stepping while the low bits would hit IDLE_ADDR.
    // A maximal 16-bit LFSR cannot stay on one low-bit pattern for 16 steps,
    // so the bounded chain always escapes.
    always_comb begin
        lfsr_next = lfsr_step(lfsr_reg);
        for (int i = 0; i < 16; i++) begin
            if (lfsr_next[INDEX_WIDTH-1:0] == IDLE_ADDR) begin
                lfsr_next = lfsr_step(lfsr_next);
            end
        end
        target_next = lfsr_next[INDEX_WIDTH-1:0];
    end

    // The LFSR state moves only when the target advances.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_reg <= 16'hACE1;
        end else if (advance) begin
            lfsr_reg <= lfsr_next;
        end
    end
`else
    // Sequential advance with wrap, stepping over the idle marker.
    always_comb begin
        target_next = target_reg + 1'b1;
        if (target_next == IDLE_ADDR) begin
            target_next = target_next + 1'b1;
        end
    end
`endif

    // Injection schedule. All outputs are registered. The flip is launched from
    // INJECT, so it is visible during the first ACK cycle. Dropping enable_i
    // aborts from any state without advancing the target or raising a timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            tcnt_reg      <= '0;
            target_reg    <= '0;
            bitflip_reg   <= IDLE_ADDR;
            inj_count_reg <= '0;
            timeout_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            bitflip_reg <= IDLE_ADDR;
            if (!enable_i) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        count_reg <= period_load;
                        state_reg <= ST_WAIT;
                        busy_reg  <= 1'b1;
                    end
                    ST_WAIT: begin
                        if (count_reg > 16'd1) begin
                            count_reg <= count_reg - 16'd1;
                        end else begin
                            count_reg <= '0;
                            state_reg <= ST_INJECT;
                        end
                    end
                    ST_INJECT: begin
                        bitflip_reg <= target_reg;
                        tcnt_reg    <= '0;
                        state_reg   <= ST_ACK;
                    end
                    ST_ACK: begin
                        if (echo_hit) begin
                            if (inj_count_reg != '1) begin
                                inj_count_reg <= inj_count_reg + 1'b1;
                            end
                            target_reg <= target_next;
                            count_reg  <= period_load;
                            state_reg  <= ST_WAIT;
                        end else if (echo_expired) begin
                            timeout_reg <= 1'b1;
                            target_reg  <= target_next;
                            count_reg   <= period_load;
                            state_reg   <= ST_WAIT;
                        end else begin
                            tcnt_reg <= tcnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
            // A clear beats an acknowledge landing in the same cycle.
            if (clear_i) begin
                inj_count_reg <= '0;
            end
        end
    end

    // One saturating event accumulator per ECC line; clear beats an event.
    logic [EVT_WIDTH-1:0][ACC_WIDTH-1:0] acc_flat;

    generate
        for (genvar gi = 0; gi < EVT_WIDTH; gi++) begin : g_acc
            logic [ACC_WIDTH-1:0] acc_reg;

            // Count one per cycle while this event line is high.
            always_ff @(posedge clk_i) begin
                if (rst_i || clear_i) begin
                    acc_reg <= '0;
                end else if (cache.counters_i[gi] && (acc_reg != '1)) begin
                    acc_reg <= acc_reg + 1'b1;
                end
            end

            assign acc_flat[gi] = acc_reg;
        end
    endgenerate

    // Registered read port; selects beyond the last event line read as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_reg <= '0;
        end else if (int'(rd_sel_i) < EVT_WIDTH) begin
            rd_data_reg <= acc_flat[rd_sel_i];
        end else begin
            rd_data_reg <= '0;
        end
    end

    assign cache.bitflip_addr_o = bitflip_reg;
    assign rd_data_o            = rd_data_reg;
    assign inj_count_o          = inj_count_reg;
    assign timeout_o            = timeout_reg;
    assign busy_o               = busy_reg;

endmodule

// File: tb/tb_ecc_fault_injector.sv
// Self-checking bench for ecc_fault_injector (default sequential build).
// The bench stands in for the cache: it echoes bitflip_addr_o back one cycle
// later when echo_on is set. Expected injection timing is derived from the
// period and timeout rules, expected targets come from plain modular
// arithmetic, and expected accumulator reads come from an integer-array model.
module tb_ecc_fault_injector;
    localparam int IW   = 12;
    localparam int EW   = 6;
    localparam int AW   = 16;
    localparam int IDLE = (1 << IW) - 1;
    localparam int AMAX = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [15:0]   period;
    logic          clear;
    logic [2:0]    rd_sel;
    logic [AW-1:0] rd_data;
    logic [AW-1:0] inj_count;
    logic          timeout;
    logic          busy;
    logic          echo_on;
    logic [IW-1:0] bf;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_m [EW];
    int exp_rd;

    ecc_fault_injector_if #(.INDEX_WIDTH(IW), .EVT_WIDTH(EW)) cache_if ();

    ecc_fault_injector dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .period_i    (period),
        .clear_i     (clear),
        .rd_sel_i    (rd_sel),
        .rd_data_o   (rd_data),
        .inj_count_o (inj_count),
        .timeout_o   (timeout),
        .busy_o      (busy),
        .cache       (cache_if)
    );

    assign bf = cache_if.bitflip_addr_o;

    always #5 clk = ~clk;

    // Cache model: echo the applied flip one cycle later, or stay idle.
    always @(posedge clk) begin
        cache_if.echo_addr_i <= echo_on ? cache_if.bitflip_addr_o : IW'(IDLE);
        cyc <= cyc + 1;
    end

    // Accumulator model and the value the registered read should return.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < EW; k++) acc_m[k] <= 0;
            exp_rd <= 0;
        end else begin
            exp_rd <= (int'(rd_sel) < EW) ? acc_m[int'(rd_sel)] : 0;
            for (int k = 0; k < EW; k++) begin
                if (clear) acc_m[k] <= 0;
                else if (cache_if.counters_i[k] && acc_m[k] < AMAX) acc_m[k] <= acc_m[k] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    // Ticks until a flip shows up; lat = -1 if none within the budget.
    task automatic wait_flip(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bf !== IW'(IDLE)) begin
                lat = i;
                break;
            end
        end
    endtask

    // Ticks until timeout_o is seen; tmo = -1 if none within the budget.
    task automatic wait_timeout(input int start, input int budget, output int tmo);
        tmo = -1;
        for (int i = start; i <= budget; i++) begin
            tick();
            if (timeout === 1'b1) begin
                tmo = i;
                break;
            end
        end
    endtask

    function automatic int next_target(input int t);
        int n;
        n = (t + 1) % (1 << IW);
        if (n == IDLE) n = (n + 1) % (1 << IW);
        return n;
    endfunction

    initial begin
        int lat;
        int tmo;
        int p;
        int e;
        int exp_tgt;
        int exp_cnt;
        int t_start;
        int n_flips;
        int seen;
        bit done;
        bit prev_4094;

        rst = 1'b1; enable = 1'b0; period = 16'd4; clear = 1'b0;
        rd_sel = 3'd0; echo_on = 1'b1; cache_if.counters_i = '0;
        tick();
        tick();
        check("rst_bitflip", bf, IDLE);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check("rst_inj_count", inj_count, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;

        // Echoed injection with period 4.
        period = 16'd4; echo_on = 1'b1; enable = 1'b1;
        wait_flip(20, lat);
        check("ack_latency", lat, 6);
        check("ack_target", bf, 0);
        check("ack_busy", busy, 1);
        tick();
        check("ack_width", bf, IDLE);
        tick();
        check("ack_count", inj_count, 1);
        check("ack_no_timeout", timeout, 0);
        wait_flip(20, lat);
        check("ack_next_latency", lat, 5);
        check("ack_next_target", bf, 1);
        $display("txn ack: target 0 acknowledged, count %0d, next target %0d", inj_count, bf);
        enable = 1'b0;
        tick();

        // Echo never matches: timeout 15 cycles after the flip.
        rst = 1'b1;
        tick();
        rst = 1'b0; echo_on = 1'b0; enable = 1'b1;
        wait_flip(20, lat);
        check("tmo_flip_latency", lat, 6);
        check("tmo_target", bf, 0);
        wait_timeout(1, 20, tmo);
        check("tmo_latency", tmo, 15);
        check("tmo_count", inj_count, 0);
        tick();
        check("tmo_pulse_width", timeout, 0);
        wait_flip(20, lat);
        check("tmo_next_latency", lat, 4);
        check("tmo_next_target", bf, 1);
        $display("txn timeout: target 0 timed out after %0d cycles, next target %0d", tmo, bf);
        enable = 1'b0;
        tick();

        // Enable dropped while waiting for the echo.
        period = 16'd2; echo_on = 1'b0; enable = 1'b1;
        wait_flip(20, lat);
        check("abort_flip_target", bf, 1);
        tick(); tick(); tick();
        enable = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_timeout", timeout, 0);
        check("abort_bitflip", bf, IDLE);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (timeout === 1'b1) seen++;
        end
        check("abort_no_late_timeout", seen, 0);
        echo_on = 1'b1; enable = 1'b1;
        wait_flip(20, lat);
        check("resume_latency", lat, 4);
        check("resume_target", bf, 1);
        tick(); tick();
        check("resume_count", inj_count, 1);
        $display("txn abort/resume: target %0d resumed and acknowledged", 1);
        enable = 1'b0;
        tick();

        // Randomized injections, each started from idle.
        exp_tgt = 2;
        exp_cnt = 1;
        for (int t = 0; t < 6; t++) begin
            p = $urandom_range(0, 7);
            e = $urandom_range(0, 1);
            period = 16'(p); echo_on = e[0]; enable = 1'b1;
            wait_flip(40, lat);
            check("rnd_latency", lat, ((p < 1) ? 1 : p) + 2);
            check("rnd_target", bf, exp_tgt);
            tick();
            check("rnd_width", bf, IDLE);
            if (e == 1) begin
                tick();
                exp_cnt++;
                check("rnd_count", inj_count, exp_cnt);
            end else begin
                wait_timeout(2, 20, tmo);
                check("rnd_timeout", tmo, 15);
                check("rnd_count_held", inj_count, exp_cnt);
            end
            $display("txn rnd %0d: period %0d echo %0d target %0d count %0d", t, p, e, exp_tgt, inj_count);
            exp_tgt = next_target(exp_tgt);
            enable = 1'b0;
            tick();
        end

        // Randomized accumulator traffic with occasional clears.
        for (int t = 0; t < 200; t++) begin
            cache_if.counters_i = EW'($urandom);
            clear = ($urandom_range(0, 15) == 0);
            rd_sel = 3'($urandom_range(0, 7));
            tick();
            check("acc_rand", rd_data, exp_rd);
        end
        $display("txn acc: 200 random event cycles read back");
        cache_if.counters_i = '0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_count", inj_count, 0);

        // Hold events 0 and 5 while sweeping targets through the wrap.
        t_start = cyc;
        cache_if.counters_i = 6'b100001; rd_sel = 3'd0;
        period = 16'd1; echo_on = 1'b1; enable = 1'b1;
        n_flips = 0;
        done = 1'b0;
        prev_4094 = 1'b0;
        for (int it = 0; it < 5000 && !done; it++) begin
            wait_flip(10, lat);
            check("sweep_latency", lat, (it == 0) ? 3 : 4);
            check("sweep_target", bf, exp_tgt);
            n_flips++;
            if (prev_4094) begin
                check("wrap_after_4094", bf, 0);
                $display("txn wrap: target after 4094 is %0d", bf);
                done = 1'b1;
            end
            prev_4094 = (exp_tgt == 4094);
            exp_tgt = next_target(exp_tgt);
        end
        check("sweep_completed", done, 1);
        enable = 1'b0;
        tick();
        check("sweep_count", inj_count, n_flips - 1);
        while (cyc - t_start < 70000) tick();
        cache_if.counters_i = '0;
        tick();
        rd_sel = 3'd0; tick(); check("sat_acc0", rd_data, 16'hFFFF);
        rd_sel = 3'd5; tick(); check("sat_acc5", rd_data, 16'hFFFF);
        rd_sel = 3'd1; tick(); check("quiet_acc1", rd_data, 0);
        rd_sel = 3'd7; tick(); check("sel7_zero", rd_data, 0);
        $display("txn saturate: acc0/acc5 saturated after %0d cycles", cyc - t_start);

        // Clear coincident with an event on line 2.
        cache_if.counters_i = 6'b000100; rd_sel = 3'd2;
        tick(); tick(); tick();
        check("acc2_pre_clear", rd_data, 2);
        clear = 1'b1;
        tick();
        clear = 1'b0; cache_if.counters_i = '0;
        tick();
        check("clear_wins", rd_data, 0);
        check("clear_model", rd_data, exp_rd);
        $display("txn clear: acc2 reads %0d after clear with event", rd_data);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ecc_fault_injector.md
ECC_FAULT_INJECTOR -- requirements
Module: ecc_fault_injector

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 12, meaning the width of the dcache index driven to the cache bitflip_addr_i.
REQ-002 SHALL have parameter EVT_WIDTH, default 6, meaning the number of ECC event lines taken from the cache counters_o.
REQ-003 SHALL have parameter ACC_WIDTH, default 16, meaning the width of each saturating accumulator.
REQ-004 SHALL have parameter IDLE_ADDR, default all-ones (INDEX_WIDTH bits), meaning the "no injection" address value.
REQ-005 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles to wait for the injection echo.
REQ-006 SHALL have port clk_i  in  1  the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-008 SHALL have port enable_i  in  1  level; high runs the injection schedule.
REQ-009 SHALL have port period_i  in  16  cycles between injections.
REQ-010 SHALL have port counters_i  in  EVT_WIDTH  per-cycle ECC event pulses from the cache counters_o.
REQ-011 SHALL have port echo_addr_i  in  INDEX_WIDTH  the cache bitflip_addr_o echo of the applied flip.
REQ-012 SHALL have port bitflip_addr_o  out  INDEX_WIDTH  the target index to the cache bitflip_addr_i.
REQ-013 SHALL have port clear_i  in  1  single-cycle clear of all accumulators.
REQ-014 SHALL have port rd_sel_i  in  3  accumulator select.
REQ-015 SHALL have port rd_data_o  out  ACC_WIDTH  the selected accumulator.
REQ-016 SHALL have port inj_count_o  out  ACC_WIDTH  the number of acknowledged injections.
REQ-017 SHALL have port timeout_o  out  1  a one-cycle pulse on echo timeout.
REQ-018 SHALL have port busy_o  out  1  high in every state except IDLE.

Function
REQ-019 SHALL implement the FSM states IDLE, WAIT, INJECT and ACK.
REQ-020 In IDLE, when enable_i=1, SHALL load the countdown with max(period_i,1) and enter WAIT.
REQ-021 In WAIT, SHALL decrement the countdown each cycle and enter INJECT in the cycle after the countdown reaches 1, giving a period_i-cycle gap.
REQ-022 In INJECT, SHALL drive bitflip_addr_o=target for exactly one cycle, clear the timeout counter, and enter ACK.
REQ-023 In every state other than INJECT, SHALL hold bitflip_addr_o at IDLE_ADDR.
REQ-024 In ACK, when echo_addr_i==target, SHALL increment inj_count_o (saturating), advance the target, reload the countdown and enter WAIT.
REQ-025 In ACK, after TIMEOUT cycles without a match, SHALL pulse timeout_o for one cycle, advance the target without incrementing inj_count_o, and enter WAIT.
REQ-026 When enable_i=0 in any state, SHALL enter IDLE on the next cycle, preserve the target, and flag no timeout.
REQ-027 SHALL advance the target as +1 modulo 2^INDEX_WIDTH, skipping IDLE_ADDR, so that the step after IDLE_ADDR-1 yields IDLE_ADDR+1 with wrap.
REQ-028 For each k, SHALL increment accumulator k by 1 in every cycle in which counters_i[k]=1, saturating at all-ones; simultaneous bits SHALL increment independently.
REQ-029 When clear_i=1, SHALL zero all accumulators and inj_count_o, and clear SHALL win over a same-cycle event (result 0).
REQ-030 SHALL register rd_data_o with a one-cycle latency from rd_sel_i; rd_sel_i values EVT_WIDTH and above SHALL return 0.

Reset
REQ-031 On rst_i=1 at a clock edge, SHALL put the FSM in IDLE and clear the countdown and timeout counters.
REQ-032 On reset, SHALL set the target to 0, bitflip_addr_o to IDLE_ADDR, all accumulators, inj_count_o and rd_data_o to 0, and timeout_o and busy_o to 0.
REQ-033 When reset is asserted mid-injection, SHALL abort the injection with no timeout pulse and no count increment.

Configuration
REQ-034 SHALL provide the macro ECC_INJ_LFSR_EN; when defined, the target advance SHALL be a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) whose low INDEX_WIDTH bits form the target, re-stepping while the result equals IDLE_ADDR.
REQ-035 When ECC_INJ_LFSR_EN is undefined, SHALL use the sequential advance of REQ-027 and instantiate no LFSR logic.

Verification
REQ-036 Bench SHALL cover: reset, enable_i=1, period_i=4, echo returned 1 cycle after INJECT -> bitflip_addr_o=0 for one cycle at cycle 6 after enable, inj_count_o=1, next target 1.
REQ-037 Bench SHALL cover: echo never matching -> timeout_o pulses exactly 15 cycles after INJECT, inj_count_o stays 0, next injection targets 1.
REQ-038 Bench SHALL cover: target 4094 with IDLE_ADDR=4095 (sequential build) -> next target 0, and 4095 is never driven as a target.
REQ-039 Bench SHALL cover: counters_i=6'b100001 held for 70000 cycles -> rd_sel 0 and 5 both read 16'hFFFF, rd_sel 1 reads 0, rd_sel 7 reads 0.
REQ-040 Bench SHALL cover: clear_i coincident with counters_i[2]=1 -> accumulator 2 reads 0 one cycle later.
REQ-041 Bench SHALL cover: enable_i dropped during ACK -> IDLE next cycle, busy_o=0, no timeout_o, and re-enable resumes at the same target.
